// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared encodings and defaults for the memory arbiter
package sisc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   localparam int MEM_LAT_DEF    = 2;
   localparam int STARVE_MAX_DEF = 2;

endpackage

// File: rtl/mem_arb_pri.sv
// rtl/mem_arb_pri.sv - fetch/data priority decision with fetch starvation guard
module mem_arb_pri
   import sisc_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic dm_req,
   input  logic grant,
   output logic win_dm
);

   logic [2:0] starve_cnt;

   // Data normally wins; a fetch kept waiting STARVE_MAX grants gets its turn.
   assign win_dm = dm_req && !(if_req && (starve_cnt == 3'(STARVE_MAX)));

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= 3'd0;
      end else if (grant && (if_req || dm_req)) begin
         if (!win_dm)
            starve_cnt <= 3'd0;
         else if (if_req)
            starve_cnt <= starve_cnt + 3'd1;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-port memory arbiter between instruction fetch and data access
module mem_arb
   import sisc_pkg::*;
#(
   parameter int MEM_LAT    = MEM_LAT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [15:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic [31:0] dm_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   arb_state_t  state, state_nxt;
   logic        win_dm;
   logic        any_req;
   logic        we_q;
   logic [15:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  lat_cnt;

   assign any_req = if_req || dm_req;

   mem_arb_pri #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pri (
      .clk    (clk),
      .rst    (rst),
      .if_req (if_req),
      .dm_req (dm_req),
      .grant  (state == ST_IDLE),
      .win_dm (win_dm)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (lat_cnt <= 4'd1) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Requests are latched once at grant so later input changes cannot disturb the access.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner    <= OWN_IF;
         we_q     <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 32'h0000_0000;
         lat_cnt  <= 4'd0;
         if_rdata <= 32'h0000_0000;
         dm_rdata <= 32'h0000_0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner   <= win_dm ? OWN_DM : OWN_IF;
                  addr_q  <= win_dm ? dm_addr : if_addr;
                  wdata_q <= win_dm ? dm_wdata : 32'h0000_0000;
                  we_q    <= win_dm && dm_we;
               end
            end
            ST_ISSUE: lat_cnt <= 4'(MEM_LAT);
            ST_WAIT: begin
               lat_cnt <= lat_cnt - 4'd1;
               if (lat_cnt == 4'd1) begin
                  if (owner == OWN_IF)
                     if_rdata <= mem_rdata;
                  else if (!we_q)
                     dm_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != ST_IDLE);
   assign mem_en    = (state == ST_ISSUE);
   assign mem_we    = (state == ST_ISSUE) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_ack    = (state == ST_DONE) && (owner == OWN_IF);
   assign dm_ack    = (state == ST_DONE) && (owner == OWN_DM);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic [15:0] if_addr, dm_addr;
   logic [31:0] dm_wdata;
   logic        if_ack, dm_ack, mem_en, mem_we, busy, owner;
   logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;

   logic        if_req_a, if_req_b;
   logic        if_ack_a, if_ack_b;
   logic [31:0] if_rdata_a, if_rdata_b;
   logic        dm_ack_a, dm_ack_b, mem_en_a, mem_en_b, mem_we_a, mem_we_b;
   logic        busy_a, busy_b, owner_a, owner_b;
   logic [31:0] dm_rdata_a, dm_rdata_b, mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
   logic [15:0] mem_addr_a, mem_addr_b;
   logic        zero1 = 1'b0;
   logic [15:0] addr0 = 16'h0000;
   logic [31:0] zero32 = 32'h0;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_arb u_dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_arb #(.MEM_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .if_req(if_req_a), .if_addr(16'h0011), .if_ack(if_ack_a),
      .if_rdata(if_rdata_a), .dm_req(zero1), .dm_we(zero1), .dm_addr(addr0),
      .dm_wdata(zero32), .dm_ack(dm_ack_a), .dm_rdata(dm_rdata_a), .mem_en(mem_en_a),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a), .busy(busy_a), .owner(owner_a)
   );

   mem_arb #(.MEM_LAT(15)) u_lat15 (
      .clk(clk), .rst(rst), .if_req(if_req_b), .if_addr(16'h0015), .if_ack(if_ack_b),
      .if_rdata(if_rdata_b), .dm_req(zero1), .dm_we(zero1), .dm_addr(addr0),
      .dm_wdata(zero32), .dm_ack(dm_ack_b), .dm_rdata(dm_rdata_b), .mem_en(mem_en_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .busy(busy_b), .owner(owner_b)
   );

   // Memory model: data is only driven on the exact cycle MEM_LAT after mem_en.
   function automatic logic [31:0] mem_f(input logic [15:0] a);
      return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
   endfunction

   logic [16:0] d0 [1:15];
   logic [16:0] da [1:15];
   logic [16:0] db [1:15];

   always @(posedge clk) begin
      d0[1] <= {mem_en, mem_addr};
      da[1] <= {mem_en_a, mem_addr_a};
      db[1] <= {mem_en_b, mem_addr_b};
      for (int k = 2; k <= 15; k++) begin
         d0[k] <= d0[k-1];
         da[k] <= da[k-1];
         db[k] <= db[k-1];
      end
   end

   assign mem_rdata   = d0[2][16]  ? mem_f(d0[2][15:0])  : 32'hBAD0BAD0;
   assign mem_rdata_a = da[1][16]  ? mem_f(da[1][15:0])  : 32'hBAD0BAD0;
   assign mem_rdata_b = db[15][16] ? mem_f(db[15][15:0]) : 32'hBAD0BAD0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          ack_cyc, en_cnt;
   logic        ack_own, overlap, iss_we;
   logic [15:0] iss_addr;
   logic [31:0] iss_wd;

   // Holds the current request until an ack, records what was issued, then returns to IDLE.
   task automatic run_txn(input int max);
      ack_cyc = 0;
      en_cnt  = 0;
      for (int c = 1; c <= max; c++) begin
         tick();
         if (mem_en) begin
            en_cnt++;
            iss_we   = mem_we;
            iss_addr = mem_addr;
            iss_wd   = mem_wdata;
         end
         if (if_ack && dm_ack) overlap = 1'b1;
         if (if_ack || dm_ack) begin
            ack_cyc = c;
            ack_own = dm_ack;
            if_req  = 1'b0;
            dm_req  = 1'b0;
            break;
         end
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      tick();
   endtask

   logic [5:0] order;
   int         n_acks, first_ack, second_ack, cyc_a, cyc_b, na, nb, dm_seen;

   initial begin
      rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
      if_addr = 0; dm_addr = 0; dm_wdata = 0;
      if_req_a = 0; if_req_b = 0; overlap = 1'b0;
      tick(); tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
      check("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
      check("rst_owner", {31'd0, owner}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);
      rst = 1'b0;

      // Single load
      dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
      run_txn(12);
      check("load_ack_cycle", ack_cyc, 4);
      check("load_ack_owner", {31'd0, ack_own}, 32'd1);
      check("load_en_pulses", en_cnt, 1);
      check("load_rdata", dm_rdata, 32'hDEADBEEF);
      check("load_idle", {31'd0, busy}, 32'd0);

      // Store
      dm_req = 1; dm_we = 1; dm_addr = 16'h0020; dm_wdata = 32'h12345678;
      run_txn(12);
      dm_we = 0;
      check("store_ack_cycle", ack_cyc, 4);
      check("store_mem_we", {31'd0, iss_we}, 32'd1);
      check("store_mem_addr", {16'd0, iss_addr}, 32'h0020);
      check("store_mem_wdata", iss_wd, 32'h12345678);
      check("store_rdata_kept", dm_rdata, 32'hDEADBEEF);

      // Plain fetch
      if_req = 1; if_addr = 16'h0040;
      run_txn(12);
      check("fetch_ack_cycle", ack_cyc, 4);
      check("fetch_ack_owner", {31'd0, ack_own}, 32'd0);
      check("fetch_mem_we", {31'd0, iss_we}, 32'd0);
      check("fetch_rdata", if_rdata, mem_f(16'h0040));

      // Contention with both requests held continuously
      if_req = 1; if_addr = 16'h0100; dm_req = 1; dm_we = 0; dm_addr = 16'h0200;
      n_acks = 0; order = '0; first_ack = 0; second_ack = 0;
      for (int c = 1; c <= 60 && n_acks < 6; c++) begin
         tick();
         if (if_ack && dm_ack) overlap = 1'b1;
         if (if_ack || dm_ack) begin
            order[n_acks] = dm_ack;
            if (n_acks == 0) first_ack = c;
            if (n_acks == 1) second_ack = c;
            n_acks++;
         end
      end
      if_req = 0; dm_req = 0;
      tick(); tick();
      check("cont_ack_count", n_acks, 6);
      check("cont_order", {26'd0, order}, 32'b011011);
      check("cont_gap", second_ack - first_ack, 5);
      check("cont_if_rdata", if_rdata, mem_f(16'h0100));
      check("cont_dm_rdata", dm_rdata, mem_f(16'h0200));

      // Reset during WAIT of a load
      dm_req = 1; dm_we = 0; dm_addr = 16'h0030;
      tick(); tick();
      check("rmid_in_wait", {31'd0, busy}, 32'd1);
      rst = 1;
      tick();
      rst = 0; dm_req = 0;
      check("rmid_busy", {31'd0, busy}, 32'd0);
      dm_seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (dm_ack) dm_seen++;
         tick();
      end
      check("rmid_no_ack", dm_seen, 0);
      check("rmid_dm_rdata", dm_rdata, 32'd0);
      if_req = 1; if_addr = 16'h0050;
      run_txn(12);
      check("rmid_fetch_cycle", ack_cyc, 4);
      check("rmid_fetch_rdata", if_rdata, mem_f(16'h0050));

      // Early drop with address change after grant
      if_req = 1; if_addr = 16'h0060;
      na = 0; cyc_a = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) if_addr = 16'h0070;
         if (c == 2) if_req = 0;
         if (if_ack) begin
            na++;
            if (cyc_a == 0) cyc_a = c;
         end
      end
      check("drop_ack_count", na, 1);
      check("drop_ack_cycle", cyc_a, 4);
      check("drop_rdata", if_rdata, mem_f(16'h0060));
      check("drop_idle", {31'd0, busy}, 32'd0);

      // Latency sweep
      if_req_a = 1; if_req_b = 1;
      na = 0; nb = 0; cyc_a = 0; cyc_b = 0;
      for (int c = 1; c <= 25; c++) begin
         tick();
         if (if_ack_a) begin
            na++;
            if (cyc_a == 0) cyc_a = c;
            if_req_a = 0;
         end
         if (if_ack_b) begin
            nb++;
            if (cyc_b == 0) cyc_b = c;
            if_req_b = 0;
         end
      end
      check("lat1_cycle", cyc_a, 3);
      check("lat15_cycle", cyc_b, 17);
      check("lat_ack_counts", {na[15:0], nb[15:0]}, {16'd1, 16'd1});
      check("lat1_rdata", if_rdata_a, mem_f(16'h0011));
      check("lat15_rdata", if_rdata_b, mem_f(16'h0015));

      check("no_ack_overlap", {31'd0, overlap}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: MEM_LAT, default 2, memory read latency in cycles after issue; legal range 1..15.
REQ-002 Parameter: STARVE_MAX, default 2, consecutive data grants allowed while a fetch waits; legal range 1..7.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset: synchronous and active-high.
REQ-005 if_req  input  1  instruction-fetch request, held until if_ack.
REQ-006 if_addr  input  16  fetch word address.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched instruction, valid while if_ack=1 and held until the next fetch completes.
REQ-009 dm_req  input  1  data (LOD/STR) request, held until dm_ack.
REQ-010 dm_we  input  1  1=store, 0=load.
REQ-011 dm_addr  input  16  data word address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_ack  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  32  load data, valid while dm_ack=1; unchanged by stores.
REQ-015 mem_en  output  1  memory access strobe.
REQ-016 mem_we  output  1  memory write strobe.
REQ-017 mem_addr  output  16  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-020 busy  output  1  1 in every state except IDLE.
REQ-021 owner  output  1  current grant: 0=fetch, 1=data; held from grant until return to IDLE.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, DONE; all transitions on the rising edge of clk.
REQ-023 IDLE: with no request pending, the FSM remains in IDLE.
REQ-024 IDLE: on any request, the FSM latches the winner's address, write data and we, sets owner, and moves to ISSUE.
REQ-025 Arbitration: data wins a simultaneous request unless starve_cnt equals STARVE_MAX, in which case fetch wins.
REQ-026 Starvation counter: starve_cnt increments on each data grant made while if_req=1, and clears to 0 on any fetch grant.
REQ-027 ISSUE (exactly 1 cycle): mem_en=1, mem_we=latched we, mem_addr and mem_wdata driven from the latches; the FSM then moves to WAIT with the latency counter loaded with MEM_LAT.
REQ-028 WAIT: the latency counter decrements each cycle; when it reaches 1, mem_rdata is registered into the owner's rdata, except that stores leave dm_rdata unchanged; the FSM then moves to DONE.
REQ-029 DONE (exactly 1 cycle): the owner's ack is 1 and the other ack is 0; the FSM then moves to IDLE; requests are not sampled in DONE.
REQ-030 Latency: from a request sampled in IDLE to its ack is MEM_LAT+2 cycles; back-to-back accesses have a 1-cycle IDLE gap between them.
REQ-031 Requester protocol: req deasserts in the cycle after ack; a req dropped early does not abort the transaction, and its ack still pulses.
REQ-032 mem_en and mem_we are 0 outside ISSUE; mem_we is never 1 for a fetch.
REQ-033 Address and data changes on inputs after grant have no effect on the current access.
REQ-034 if_ack and dm_ack are never both 1 in the same cycle.

Reset
REQ-035 rst=1 at a rising edge forces IDLE, starve_cnt=0, latency counter=0, owner=0, and all outputs to 0, including rdata registers, busy, both acks, mem_en and mem_we.
REQ-036 Reset in the middle of a transaction abandons it without an ack; a store already issued is not undone, and nothing is retried.
REQ-037 The first request is sampled at the first rising edge with rst=0.

Structure
REQ-038 Shared package sisc_pkg holds the FSM state encoding, owner encoding (OWN_IF=0, OWN_DM=1) and the default MEM_LAT and STARVE_MAX values.
REQ-039 One sub-module, mem_arb_pri, holds the priority decision and starve_cnt; the FSM, latches and latency counter stay in mem_arb.

Verification
REQ-040 Single load: MEM_LAT=2, dm_req=1, dm_we=0, dm_addr=16'h0010, mem model returns 32'hDEADBEEF -> mem_en pulses once, then dm_ack at cycle 4 with dm_rdata=32'hDEADBEEF.
REQ-041 Store: dm_we=1, dm_addr=16'h0020, dm_wdata=32'h12345678 -> in ISSUE mem_we=1, mem_addr=16'h0020, mem_wdata=32'h12345678; dm_ack pulses and dm_rdata is unchanged.
REQ-042 Contention: if_req and dm_req held high continuously, STARVE_MAX=2 -> grant order data, data, fetch, data, data, fetch; no ack overlap.
REQ-043 Latency sweep: MEM_LAT=1 and MEM_LAT=15 fetches -> if_ack at cycles 3 and 17 respectively.
REQ-044 Reset mid-WAIT: rst=1 for one cycle during a load -> no dm_ack, busy=0 next cycle, and the next fetch completes normally.
REQ-045 Early drop: if_req deasserted in WAIT -> if_ack still pulses once, and the FSM returns to IDLE.
